// File: rtl/keccak_slice_sched.sv
// keccak_slice_sched: round/slice sequencer driving the slice-serial Keccak-f[1600] parity and chi-iota passes
module keccak_slice_sched #(
  parameter int NUM_ROUNDS = 24,
  parameter int SLICES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall,
  output logic       busy,
  output logic       done,
  output logic       phase,
  output logic [4:0] rnd_cnt,
  output logic [2:0] sub_rnd_cnt,
  output logic       slice_en,
  output logic       first_slice,
  output logic       last_slice,
  output logic       last_round
);
  typedef enum logic [1:0] {IDLE, PAR, CHI, DONE} state_t;
  state_t     state;
  logic [4:0] rnd;
  logic [2:0] sub;
  logic       sub_last;
  logic [2:0] sub_nxt;
  assign sub_last = sub == 3'(SLICES - 1);
  assign sub_nxt  = sub_last ? 3'd0 : sub + 3'd1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rnd   <= '0;
      sub   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= PAR;
          rnd   <= 5'd1;
          sub   <= '0;
        end
        PAR: if (!stall) begin
          sub <= sub_nxt;
          if (sub_last) state <= CHI;
        end
        CHI: if (!stall) begin
          sub <= sub_nxt;
          if (sub_last) begin
            state <= (rnd == 5'(NUM_ROUNDS)) ? DONE : PAR;
            rnd   <= (rnd == 5'(NUM_ROUNDS)) ? 5'd0 : rnd + 5'd1;
          end
        end
        default: begin
          state <= IDLE;
          rnd   <= '0;
          sub   <= '0;
        end
      endcase
    end
  end
  // rnd_cnt is forced to 0 outside chi passes so the iota constant is zero
  assign busy        = (state == PAR) || (state == CHI);
  assign done        = state == DONE;
  assign phase       = state == CHI;
  assign rnd_cnt     = phase ? rnd : 5'd0;
  assign sub_rnd_cnt = sub;
  assign slice_en    = busy & ~stall;
  assign first_slice = busy & (sub == 3'd0);
  assign last_slice  = busy & sub_last;
  assign last_round  = busy & (rnd == 5'(NUM_ROUNDS));
endmodule

// File: tb/tb_keccak_slice_sched.sv
// tb_keccak_slice_sched: randomized and directed checks of two sequencers (24 and 1 rounds) against a slice-index model
module tb_keccak_slice_sched;
  logic       clk = 0, rst_n = 0, start = 0, stall = 0;
  logic [1:0] busy, done, phase, slice_en, first_slice, last_slice, last_round;
  logic [4:0] rnd_cnt[2];
  logic [2:0] sub_rnd_cnt[2];
  int  n_cmp = 0, n_bad = 0, t = 0;
  bit  run[2], dn[2];
  int  idx[2], t0[2], lat[2];
  int  en_cnt, busy_cnt, done_cnt;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    keccak_slice_sched #(.NUM_ROUNDS(g == 0 ? 24 : 1), .SLICES(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
      .busy(busy[g]), .done(done[g]), .phase(phase[g]),
      .rnd_cnt(rnd_cnt[g]), .sub_rnd_cnt(sub_rnd_cnt[g]),
      .slice_en(slice_en[g]), .first_slice(first_slice[g]),
      .last_slice(last_slice[g]), .last_round(last_round[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @step %0d: got %0d expected %0d", tag, t, got, exp);
    end
  endtask

  // model: a permutation is a linear walk over 16*N slice positions
  task automatic step(input bit r, input bit s, input bit st);
    rst_n = r; start = s; stall = st;
    #1;
    for (int i = 0; i < 2; i++) begin
      int n = (i == 0) ? 24 : 1;
      int k = idx[i];
      bit ph = run[i] && ((k / 8) % 2 == 1);
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(run[i]));
      chk($sformatf("done%0d", i), 32'(done[i]), 32'(dn[i]));
      chk($sformatf("phase%0d", i), 32'(phase[i]), 32'(ph));
      chk($sformatf("rnd_cnt%0d", i), 32'(rnd_cnt[i]), ph ? k / 16 + 1 : 0);
      chk($sformatf("sub%0d", i), 32'(sub_rnd_cnt[i]), run[i] ? k % 8 : 0);
      chk($sformatf("slice_en%0d", i), 32'(slice_en[i]), 32'(run[i] && !st));
      chk($sformatf("first%0d", i), 32'(first_slice[i]), 32'(run[i] && k % 8 == 0));
      chk($sformatf("last%0d", i), 32'(last_slice[i]), 32'(run[i] && k % 8 == 7));
      chk($sformatf("last_round%0d", i), 32'(last_round[i]), 32'(run[i] && k / 16 + 1 == n));
    end
    busy_cnt += 32'(busy[0]);
    en_cnt   += 32'(slice_en[0]);
    if (done[0]) begin done_cnt++; lat[0] = t - t0[0]; end
    if (done[1]) lat[1] = t - t0[1];
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      int n = (i == 0) ? 24 : 1;
      if (!r) begin run[i] = 0; idx[i] = 0; dn[i] = 0; end
      else if (dn[i]) dn[i] = 0;
      else if (run[i]) begin
        if (!st) begin
          if (idx[i] == 16 * n - 1) begin run[i] = 0; dn[i] = 1; idx[i] = 0; end
          else idx[i]++;
        end
      end else if (s) begin run[i] = 1; idx[i] = 0; t0[i] = t; end
    end
    t++;
    @(negedge clk);
  endtask

  task automatic clr_cnt();
    en_cnt = 0; busy_cnt = 0; done_cnt = 0; lat[0] = -1; lat[1] = -1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin run[i] = 0; dn[i] = 0; idx[i] = 0; t0[i] = 0; end
    clr_cnt();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    // full run, no stall
    clr_cnt();
    step(1, 1, 0);
    for (int i = 0; i < 395; i++) step(1, 0, 0);
    chk("full_done_lat", lat[0], 385);
    chk("full_busy_cycles", busy_cnt, 384);
    chk("full_slice_en", en_cnt, 384);
    chk("full_done_count", done_cnt, 1);
    chk("nr1_done_lat", lat[1], 17);
    // stall five cycles at chi round 7, slice 3
    clr_cnt();
    step(1, 1, 0);
    for (int i = 0; i < 107; i++) step(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_rnd", rnd_cnt[0], 7);
      chk("stall_sub", sub_rnd_cnt[0], 3);
      step(1, 0, 1);
    end
    for (int i = 0; i < 300; i++) step(1, 0, 0);
    chk("stall_done_lat", lat[0], 390);
    chk("stall_slice_en", en_cnt, 384);
    // start while busy and during done is ignored
    clr_cnt();
    step(1, 1, 0);
    for (int i = 1; i < 50; i++) step(1, 0, 0);
    step(1, 1, 0);
    for (int i = 51; i < 385; i++) step(1, 0, 0);
    chk("done_cycle_seen", 32'(done[0]), 1);
    step(1, 1, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0);
    chk("ignored_done_lat", lat[0], 385);
    chk("ignored_done_count", done_cnt, 1);
    chk("ignored_idle", 32'(busy[0]), 0);
    // reset during parity round 12, slice 5
    clr_cnt();
    step(1, 1, 0);
    for (int i = 0; i < 181; i++) step(1, 0, 0);
    chk("pre_rst_sub", sub_rnd_cnt[0], 5);
    chk("pre_rst_phase", 32'(phase[0]), 0);
    step(0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    chk("rst_no_done", done_cnt, 0);
    clr_cnt();
    step(1, 1, 0);
    for (int i = 0; i < 390; i++) step(1, 0, 0);
    chk("post_rst_done_lat", lat[0], 385);
    chk("post_rst_slice_en", en_cnt, 384);
    // random start/stall/reset traffic
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 299) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/keccak_slice_sched.md
# keccak_slice_sched

Round/slice sequencer for the slice-serial Keccak-f[1600] core. Each round runs over 8 slices of 8 bits per lane (200-bit slice state). It runs the 24 rounds as two 8-slice passes per round: a theta column-parity pass, then a theta-apply/rho-pi/chi-iota pass. It drives the round index and sub-round index consumed by the chi-iota stage, plus the slice enables and the start/busy/done handshake used by the hash top level.

## Interface
- NUM_ROUNDS, 24, rounds per permutation (legal 1..24; round index runs 1..NUM_ROUNDS)
- SLICES, 8, slices per lane pass (power of two, 8 for 64-bit lanes)
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle request to begin a permutation
- stall  in  1  state-memory backpressure; freezes sequencing while high
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last slice of the last round
- phase  out  1  0 = parity pass, 1 = chi pass
- rnd_cnt  out  5  round index to the chi-iota stage; equals the current round (1..NUM_ROUNDS) only when phase=1 and busy=1, otherwise 0, which forces a zero iota constant
- sub_rnd_cnt  out  3  current slice index 0..SLICES-1; 0 when idle
- slice_en  out  1  slice-state write enable = busy & ~stall
- first_slice  out  1  busy & sub_rnd_cnt==0
- last_slice  out  1  busy & sub_rnd_cnt==SLICES-1
- last_round  out  1  busy & round==NUM_ROUNDS

## Operation
- States: IDLE, PAR, CHI, DONE. Internal round counter rnd (5 bit) and slice counter sub (3 bit). All state is registered. Outputs are decoded from the registers and are glitch-free relative to clk.
- IDLE: start=1 -> PAR, rnd=1, sub=0. The stall value does not gate acceptance.
- PAR/CHI: on each cycle with stall=0, sub increments.
  - PAR, sub==SLICES-1 -> CHI, sub=0, rnd unchanged.
  - CHI, sub==SLICES-1, rnd<NUM_ROUNDS -> PAR, sub=0, rnd+1.
  - CHI, sub==SLICES-1, rnd==NUM_ROUNDS -> DONE.
  - stall=1 holds all registers. slice_en=0 during stall.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. In DONE, rnd and sub are cleared to 0 and busy=0.
- start while in PAR, CHI or DONE is ignored; it is not queued.
- rnd never exceeds NUM_ROUNDS. sub wraps only via the transitions above.
- Reset (rst_n=0 at a clock edge), from any state including mid-permutation: next state IDLE, rnd=0, sub=0. Any in-progress permutation is abandoned with no done pulse.

## Timing
- Reset values: busy=0, done=0, phase=0, rnd_cnt=0, sub_rnd_cnt=0, slice_en=0, first_slice=0, last_slice=0, last_round=0.
- start is sampled at edge T0. busy=1, phase=0, sub_rnd_cnt=0 appear in cycle T0+1.
- With no stall:
  - cycles T0+1..T0+8 are round-1 PAR.
  - T0+9..T0+16 are round-1 CHI (rnd_cnt=1).
  - The last CHI slice of round 24 is at T0+384.
  - done=1 at T0+385, with busy=0 in that same cycle.
  - A new start can be accepted at the T0+386 edge (IDLE).
- Each stall cycle adds exactly one cycle to the total latency.
- The chi-iota stage is combinational: rnd_cnt and sub_rnd_cnt are valid for the whole cycle in which slice_en writes that slice.

## Test plan
- Reset values: hold rst_n=0 for 3 cycles -> all outputs 0. Release with start=0 for 10 cycles -> outputs still 0.
- Full run: start pulse at T0, no stall ->
  - busy high for cycles T0+1..T0+384.
  - rnd_cnt=0 in every PAR cycle.
  - CHI round r shows rnd_cnt=r with sub_rnd_cnt 0..7.
  - done single pulse at T0+385.
  - slice_en count = 384.
- Stall: assert stall for 5 cycles at CHI round 7, sub 3 -> rnd_cnt=7 and sub_rnd_cnt=3 held, slice_en=0, done shifts to T0+390.
- Start while busy: pulse start at T0+50 and again in the DONE cycle -> both ignored, no second run, IDLE after done.
- Reset mid-run: rst_n=0 during PAR round 12, sub 5 -> next cycle IDLE with all outputs 0 and no done pulse. A subsequent start runs a full 384-cycle permutation.
- Boundaries:
  - NUM_ROUNDS=1 -> done at T0+17, last_round high throughout the run.
  - first_slice and last_slice each assert exactly once per pass.
